// File: rtl/gpi_irq_pkg.sv
// Shared register map and prescaler width for the GPI interrupt controller.
package gpi_irq_pkg;
  localparam int DIV_W = 16;

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_RISE_EN = 3'd1,
    REG_FALL_EN = 3'd2,
    REG_STATUS  = 3'd3,
    REG_MASK    = 3'd4,
    REG_DIV     = 3'd5
  } reg_idx_e;
endpackage

// File: rtl/gpi_filter.sv
// One input bit: 2-flop synchronizer, tick-sampled 2-entry history and debounced level.
module gpi_filter (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic filt,
  output logic filt_nxt
);
  logic       s1, s2;
  logic [1:0] hist;

  // filt only moves once three consecutive ticked samples agree
  always_comb begin
    filt_nxt = filt;
    if (tick && (hist[0] == s2) && (hist[1] == s2)) filt_nxt = s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= '0;
      filt <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      if (tick) hist <= {hist[0], s2};
      filt <= filt_nxt;
    end
  end
endmodule

// File: rtl/gpi_irq_ctrl.sv
// GPI interrupt controller: prescaled debounce, edge status (W1C), masked level irq.
module gpi_irq_ctrl
  import gpi_irq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  input  logic [W-1:0] din,
  output logic         irq
);
  logic [W-1:0]     filt, filt_nxt;
  logic [W-1:0]     rise_en, fall_en, status, mask;
  logic [W-1:0]     events, w1c;
  logic [DIV_W-1:0] div, count;
  logic [2:0]       idx;
  logic             wr_en, tick;

  // reads are side-effect free and only addr[2:0] is decoded
  logic unused_bits;
  assign unused_bits = &{1'b0, read, addr[4:3], wr_data};

  assign idx   = addr[2:0];
  assign wr_en = cs & write;
  assign tick  = (count == div);

  for (genvar gi = 0; gi < W; gi++) begin : g_filt
    gpi_filter u_filt (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .din      (din[gi]),
      .filt     (filt[gi]),
      .filt_nxt (filt_nxt[gi])
    );
  end

  assign events = (~filt & filt_nxt & rise_en) | (filt & ~filt_nxt & fall_en);
  assign w1c    = (wr_en && idx == REG_STATUS) ? wr_data[W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      div     <= '0;
      rise_en <= '0;
      fall_en <= '0;
      mask    <= '0;
      status  <= '0;
      irq     <= 1'b0;
    end else begin
      count <= (tick || (wr_en && idx == REG_DIV)) ? '0 : count + DIV_W'(1);
      if (wr_en) begin
        case (idx)
          REG_RISE_EN: rise_en <= wr_data[W-1:0];
          REG_FALL_EN: fall_en <= wr_data[W-1:0];
          REG_MASK:    mask    <= wr_data[W-1:0];
          REG_DIV:     div     <= wr_data[DIV_W-1:0];
          default: ;
        endcase
      end
      // a new event wins over a same-cycle clear of that bit
      status <= (status & ~w1c) | events;
      irq    <= |(status & mask);
    end
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      REG_DATA:    rd_data[W-1:0]     = filt;
      REG_RISE_EN: rd_data[W-1:0]     = rise_en;
      REG_FALL_EN: rd_data[W-1:0]     = fall_en;
      REG_STATUS:  rd_data[W-1:0]     = status;
      REG_MASK:    rd_data[W-1:0]     = mask;
      REG_DIV:     rd_data[DIV_W-1:0] = div;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_gpi_irq_ctrl.sv
// Bench for gpi_irq_ctrl: directed cases plus randomized traffic against a behavioural model.
module tb_gpi_irq_ctrl;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset, cs, read, write;
  logic [4:0]    addr;
  logic [31:0]   wr_data, rd_data;
  logic [W-1:0]  din;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpi_irq_ctrl #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .din     (din),
    .irq     (irq)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]  m_filt, m_rise, m_fall, m_status, m_mask;
  logic [15:0]   m_div;
  logic          m_irq;
  logic [W-1:0]  sync_q[$];   // din as seen two edges later
  logic [W-1:0]  tick_q[$];   // last two samples taken on ticks
  longint        n = 0, clr = 0;
  bit            m_on = 0;

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[W-1:0] = m_filt;
      3'd1: r[W-1:0] = m_rise;
      3'd2: r[W-1:0] = m_fall;
      3'd3: r[W-1:0] = m_status;
      3'd4: r[W-1:0] = m_mask;
      3'd5: r[15:0]  = m_div;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0] s2v, nf, ev, clrm;
    logic         tk;
    n++;
    if (reset) begin
      m_filt = '0; m_rise = '0; m_fall = '0; m_status = '0; m_mask = '0;
      m_div = '0; m_irq = 1'b0; clr = n; m_on = 1;
      sync_q = '{'0, '0};
      tick_q = '{'0, '0};
    end else if (m_on) begin
      s2v = sync_q[0];
      tk  = ((n - clr - 1) % (longint'(m_div) + 1)) == longint'(m_div);
      nf  = m_filt;
      if (tk) begin
        for (int i = 0; i < W; i++)
          if (tick_q[0][i] == s2v[i] && tick_q[1][i] == s2v[i]) nf[i] = s2v[i];
        tick_q.push_back(s2v);
        void'(tick_q.pop_front());
      end
      ev    = (~m_filt & nf & m_rise) | (m_filt & ~nf & m_fall);
      m_irq = |(m_status & m_mask);
      clrm  = (cs && write && addr[2:0] == 3'd3) ? wr_data[W-1:0] : '0;
      m_status = (m_status & ~clrm) | ev;
      m_filt   = nf;
      if (cs && write) begin
        case (addr[2:0])
          3'd1: m_rise = wr_data[W-1:0];
          3'd2: m_fall = wr_data[W-1:0];
          3'd4: m_mask = wr_data[W-1:0];
          3'd5: begin m_div = wr_data[15:0]; clr = n; end
          default: ;
        endcase
      end
      sync_q.push_back(din);
      void'(sync_q.pop_front());
    end
    #1;
    if (m_on) begin
      chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
      chk("model_rd", rd_data, exp_rd(addr[2:0]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = {2'($urandom), a}; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0; wr_data = $urandom;
  endtask

  task automatic rdchk(input string name, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = {2'($urandom), a}; read = 1'b1;
    #1;
    chk(name, rd_data, exp);
    read = 1'b0;
  endtask

  initial begin
    int lat;
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    for (int a = 0; a < 8; a++) rdchk("reset_rd", 3'(a), 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    rdchk("addr6_ignored", 3'd6, 32'h0);
    rdchk("addr7_ignored", 3'd7, 32'h0);

    // rise latency with DIV=0
    wr(3'd1, 32'h01);
    wr(3'd4, 32'h01);
    @(negedge clk);
    din = 8'h01; addr = 5'd0;
    for (int j = 0; j <= 5; j++) begin
      @(posedge clk); #1;
      if (j == 3) chk("lat_data_k3", rd_data, 32'h00);
      if (j == 4) begin
        chk("lat_data_k4", rd_data, 32'h01);
        chk("lat_irq_k4", {31'b0, irq}, 32'h0);
      end
      if (j == 5) chk("lat_irq_k5", {31'b0, irq}, 32'h1);
    end
    rdchk("lat_status", 3'd3, 32'h01);

    // W1C collides with a new rise on the same bit
    @(negedge clk); din = 8'h00;
    repeat (8) @(negedge clk);
    din = 8'h01;
    repeat (4) @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = 5'd3; wr_data = 32'h01;
    @(posedge clk); #1;
    chk("w1c_vs_set", rd_data, 32'h01);
    @(negedge clk); cs = 1'b0; write = 1'b0;
    rdchk("data_after_rise", 3'd0, 32'h01);
    wr(3'd3, 32'h01);
    chk("irq_lags_clear", {31'b0, irq}, 32'h1);
    rdchk("status_cleared", 3'd3, 32'h00);
    chk("irq_cleared", {31'b0, irq}, 32'h0);

    // 2-cycle glitch on bit 1 is rejected
    wr(3'd1, 32'h03);
    wr(3'd4, 32'h03);
    @(negedge clk); din = 8'h03;
    @(negedge clk);
    @(negedge clk); din = 8'h01;
    repeat (10) @(negedge clk);
    rdchk("glitch_data", 3'd0, 32'h01);
    rdchk("glitch_status", 3'd3, 32'h00);
    chk("glitch_irq", {31'b0, irq}, 32'h0);

    // prescaled debounce, DIV=3
    wr(3'd1, 32'h05);
    wr(3'd5, 32'h03);
    @(negedge clk); din = 8'h05; addr = 5'd0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rd_data[2] && lat == 0) lat = c - 1;
    end
    checks++;
    if (lat < 10 || lat > 13) begin
      errors++;
      $display("FAIL div3_latency got %0d expected 10..13", lat);
    end
    wr(3'd5, 32'h0);

    // din held high through reset, then fall on all bits with irq masked
    @(negedge clk); reset = 1'b1; din = 8'hFF;
    @(negedge clk); reset = 1'b0;
    wr(3'd2, 32'hFF);
    repeat (8) @(negedge clk);
    rdchk("hold_high_data", 3'd0, 32'hFF);
    rdchk("hold_high_status", 3'd3, 32'h00);
    @(negedge clk); din = 8'h00;
    repeat (8) @(negedge clk);
    rdchk("fall_status", 3'd3, 32'hFF);
    chk("fall_irq_masked", {31'b0, irq}, 32'h0);
    wr(3'd4, 32'h80);
    chk("mask_irq_lag", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("mask_irq", {31'b0, irq}, 32'h1);

    // reset beats a same-cycle write
    @(negedge clk);
    reset = 1'b1; cs = 1'b1; write = 1'b1; addr = 5'd4; wr_data = 32'hFF;
    @(negedge clk);
    reset = 1'b0; cs = 1'b0; write = 1'b0;
    rdchk("reset_over_write", 3'd4, 32'h00);

    // randomized traffic, checked every cycle by the model
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      for (int i = 0; i < W; i++)
        if ($urandom_range(15) == 0) din[i] = ~din[i];
      reset = ($urandom_range(499) == 0);
      addr  = 5'($urandom);
      read  = 1'($urandom);
      if ($urandom_range(7) == 0) begin
        cs = ($urandom_range(3) != 0);
        write = 1'b1;
        wr_data = (addr[2:0] == 3'd5) ? 32'($urandom_range(3)) : $urandom;
      end else begin
        cs = 1'($urandom);
        write = 1'b0;
        wr_data = $urandom;
      end
    end
    @(negedge clk);
    reset = 1'b0; cs = 1'b0; write = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
